// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared types and constants for the daily alarm unit.
//   alarm_state_t : alarm controller states
//   HOUR_W/MIN_W  : decimal weights of the hour/minute fields in HHMMSS
//   MAX_HOUR/MIN  : wrap limits of the editable alarm fields
//   to_hhmmss()   : packs an hour/minute pair into HHMMSS with seconds = 00
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } alarm_state_t;

    localparam int HOUR_W    = 10000;
    localparam int MIN_W     = 100;
    localparam int MAX_HOUR  = 23;
    localparam int MIN_BITS  = 6;
    localparam int HOUR_BITS = 5;
    localparam int MAX_MIN   = 59;
    localparam int TIME_BITS = 24;

    // Largest result is 23*10000 + 59*100 = 235900, which fits in 24 bits.
    function automatic logic [TIME_BITS-1:0] to_hhmmss(
        input logic [HOUR_BITS-1:0] hour,
        input logic [MIN_BITS-1:0]  min
    );
        return TIME_BITS'(hour) * TIME_BITS'(HOUR_W)
             + TIME_BITS'(min)  * TIME_BITS'(MIN_W);
    endfunction

endpackage

// File: rtl/alarm_unit.sv
// alarm_unit
// Settable daily alarm placed downstream of the timer. It compares a user-set
// alarm hour/minute against the running HHMMSS time and, when the time moves
// onto the alarm value, rings a blinking LED. Ringing stops on dismiss or after
// RING_SEC seconds; snooze silences it for SNOOZE_SEC seconds and then re-rings.
//
// Ports
//   clk        in   system clock, the only clock
//   rst_n      in   synchronous active-low reset
//   number     in   current time HHMMSS (decimal-coded), changes <= 1/s
//   arm        in   level, 1 = alarm enabled
//   inc_hour   in   pulse, alarm hour +1 (23 wraps to 0)
//   inc_min    in   pulse, alarm minute +1 (59 wraps to 0, no hour carry)
//   snooze     in   pulse, ringing -> snooze
//   dismiss    in   pulse, ringing/snooze -> armed
//   alarm_time out  alarm value as HHMMSS, seconds field 00
//   ringing    out  high while ringing
//   led        out  blinking alarm LED, 0 unless ringing
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int RST_HOUR   = 7,
    parameter int RST_MIN    = 0,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int BLINK_HALF = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TIME_BITS-1:0] number,
    input  logic                 arm,
    input  logic                 inc_hour,
    input  logic                 inc_min,
    input  logic                 snooze,
    input  logic                 dismiss,
    output logic [TIME_BITS-1:0] alarm_time,
    output logic                 ringing,
    output logic                 led
);

    localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    alarm_state_t          r_state;
    alarm_state_t          w_state_nxt;
    logic [HOUR_BITS-1:0]  r_hour;
    logic [MIN_BITS-1:0]   r_min;
    logic [TIME_BITS-1:0]  r_prev_number;
    logic [CNT_W-1:0]      r_sec_cnt;
    logic [BLK_W-1:0]      r_blink_cnt;
    logic                  r_led;

    logic [TIME_BITS-1:0]  w_alarm_time;
    logic                  w_sec_tick;
    logic                  w_hit;
    logic [CNT_W-1:0]      w_sec_inc;
    logic                  w_ring_done;
    logic                  w_snooze_done;
    logic                  w_state_change;

    function automatic logic [HOUR_BITS-1:0] next_hour(input logic [HOUR_BITS-1:0] h);
        return (h == HOUR_BITS'(MAX_HOUR)) ? '0 : h + 1'b1;
    endfunction

    function automatic logic [MIN_BITS-1:0] next_min(input logic [MIN_BITS-1:0] m);
        return (m == MIN_BITS'(MAX_MIN)) ? '0 : m + 1'b1;
    endfunction

    assign w_alarm_time = to_hhmmss(r_hour, r_min);

    // Any change of the time value is a second tick, including the timer's
    // own reset jumping back to 000000.
    assign w_sec_tick = (number != r_prev_number);

    // Only a transition onto the alarm value rings; a value that already sat
    // there when the unit was armed does not. Uses the pre-edit alarm value.
    assign w_hit = w_sec_tick && (number == w_alarm_time);

    // Timeouts fire on the tick that would bring the count up to the limit.
    assign w_sec_inc     = r_sec_cnt + 1'b1;
    assign w_ring_done   = w_sec_tick && (w_sec_inc == CNT_W'(RING_SEC));
    assign w_snooze_done = w_sec_tick && (w_sec_inc == CNT_W'(SNOOZE_SEC));

    assign w_state_change = (w_state_nxt != r_state);

    // ---- time sampling and alarm editing ----
    always_ff @(posedge clk) begin
        // The previous time is loaded even in reset so the first cycle after
        // reset never sees a tick.
        r_prev_number <= number;
        if (!rst_n) begin
            r_hour <= HOUR_BITS'(RST_HOUR);
            r_min  <= MIN_BITS'(RST_MIN);
        end else begin
            if (inc_hour) begin
                r_hour <= next_hour(r_hour);
            end
            if (inc_min) begin
                r_min <= next_min(r_min);
            end
        end
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DISARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_state_nxt = r_state;
        if (!arm) begin
            // Disarming overrides every other event.
            w_state_nxt = DISARMED;
        end else begin
            unique case (r_state)
                DISARMED: w_state_nxt = ARMED;
                ARMED: begin
                    if (w_hit) begin
                        w_state_nxt = RINGING;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        w_state_nxt = ARMED;
                    end else if (snooze) begin
                        w_state_nxt = SNOOZE;
                    end else if (w_ring_done) begin
                        w_state_nxt = ARMED;
                    end
                end
                SNOOZE: begin
                    if (dismiss) begin
                        w_state_nxt = ARMED;
                    end else if (w_snooze_done) begin
                        w_state_nxt = RINGING;
                    end
                end
                default: w_state_nxt = DISARMED;
            endcase
        end
    end

    // ---- seconds counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
        end else if (w_state_change) begin
            r_sec_cnt <= '0;
        end else if (w_sec_tick && (r_state == RINGING || r_state == SNOOZE)) begin
            r_sec_cnt <= w_sec_inc;
        end
    end

    // ---- blink divider ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_state_nxt == RINGING) begin
            if (r_state != RINGING) begin
                // Each ring (first or after snooze) starts with the LED lit.
                r_led       <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
                r_led       <= ~r_led;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_led       <= 1'b0;
            r_blink_cnt <= '0;
        end
    end

    assign alarm_time = w_alarm_time;
    assign ringing    = (r_state == RINGING);
    assign led        = r_led;

endmodule

// File: doc/alarm_unit.md
# alarm_unit

Settable daily alarm that sits directly downstream of `timer`. It consumes the same 24-bit HHMMSS time value that feeds the display path (decimal-coded binary, e.g. 13:05:09 = 130509). It holds a user-set alarm hour and minute, and compares them against the running time. On a match it rings: a blinking LED with a timeout, snooze and dismiss. It drives the alarm LED and exports the alarm time in the same HHMMSS encoding, so the display mux can show it.

## Interface
- `RST_HOUR`, 7: alarm hour after reset (0–23).
- `RST_MIN`, 0: alarm minute after reset (0–59).
- `RING_SEC`, 60: seconds of ringing before auto-stop.
- `SNOOZE_SEC`, 300: seconds of snooze before re-ring.
- `BLINK_HALF`, 50_000_000: clk cycles per LED half-period.
- `clk`  in  1  system clock (100 MHz); the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `number`  in  24  current time HHMMSS from `timer`; changes at most once per second.
- `arm`  in  1  level; 1 = alarm enabled (switch).
- `inc_hour`  in  1  one-cycle pulse (debounced); increment alarm hour.
- `inc_min`  in  1  one-cycle pulse; increment alarm minute.
- `snooze`  in  1  one-cycle pulse.
- `dismiss`  in  1  one-cycle pulse.
- `alarm_time`  out  24  hour*10000 + min*100 (seconds field always 00).
- `ringing`  out  1  high in RINGING state.
- `led`  out  1  alarm LED; blinks while ringing, else 0.

## Operation
- Registers: `hour` (5 b), `min` (6 b), `prev_number` (24 b), state, `sec_cnt`, `blink_cnt`, `led`.
- `sec_tick` = (`number` != `prev_number`). `prev_number` <= `number` every cycle.
- `hit` = `sec_tick` && (`number` == `alarm_time`). A hit is a transition into the alarm value. A static match after arming does not ring.
- Editing the alarm:
  - `inc_hour`: 23 → 0 wrap.
  - `inc_min`: 59 → 0 wrap, with no carry into hour.
  - Edits are allowed in every state and do not change state.
  - `hit` uses the pre-edit value.
- States (package enum):
  - DISARMED → ARMED when `arm`=1.
  - ARMED → RINGING on `hit`.
  - RINGING → ARMED on `dismiss`, or when `sec_cnt` reaches RING_SEC.
  - RINGING → SNOOZE on `snooze`.
  - SNOOZE → RINGING when `sec_cnt` reaches SNOOZE_SEC.
  - SNOOZE → ARMED on `dismiss`.
- `arm`=0 forces DISARMED from any state on the next edge. This has priority over everything except reset.
- Priority in RINGING: `arm`=0 > `dismiss` > `snooze` > timeout.
- `sec_cnt`:
  - Cleared on every state entry.
  - Incremented on `sec_tick` in RINGING/SNOOZE.
  - Width $clog2(max(RING_SEC,SNOOZE_SEC)+1).
  - Timeout is evaluated on the tick that makes the count equal the limit.
- Blink:
  - On entering RINGING: `led`=1 and `blink_cnt`=0.
  - `led` toggles every BLINK_HALF cycles while in RINGING.
  - `led`=0 in all other states.
- `alarm_time` is combinational from `hour`/`min`. Weights are 10000 and 100; the result fits in 24 b (max 235900).
- A `timer` reset making `number` jump to 000000 counts as a tick. It rings if the alarm is 00:00 and the unit is ARMED.

## Timing
- Reset values:
  - `hour`=RST_HOUR, `min`=RST_MIN, so `alarm_time`=RST_HOUR*10000+RST_MIN*100.
  - State DISARMED; `ringing`=0, `led`=0.
  - `prev_number`=`number` is sampled at reset, so there is no tick on the first cycle after reset.
- Reset asserted mid-ring or mid-snooze clears everything on that edge.
- `ringing` and `led` rise 1 cycle after the first cycle `number` equals `alarm_time`.
- `dismiss`/`snooze` take effect 1 cycle after the pulse.
- `alarm_time` updates 1 cycle after `inc_*`.
- Ring duration = exactly RING_SEC ticks after entry.

## Structure
- `alarm_pkg`: `alarm_state_t` enum {DISARMED, ARMED, RINGING, SNOOZE}; constants HOUR_W=10000, MIN_W=100, MAX_HOUR=23, MAX_MIN=59.
- Single module, no sub-modules; blink divider and tick detector are inline.

## Test plan
Bench parameters: RING_SEC=3, SNOOZE_SEC=5, BLINK_HALF=4; the bench drives `number` directly.
- Reset with RST_HOUR=7 → `alarm_time`=070000, `ringing`=0, `led`=0. 24 `inc_hour` pulses → back to 070000. 60 `inc_min` pulses → 070000 (no hour carry).
- `arm`=1, `number` 065959→070000 → `ringing`=1 next cycle. `led` toggles every 4 cycles. After 3 further `number` changes → `ringing`=0, state ARMED.
- Ringing, `snooze` pulse → `ringing`=0 next cycle. After 5 ticks → `ringing`=1. Then `dismiss` → ARMED.
- `snooze` and `dismiss` in the same cycle → ARMED, not SNOOZE. `arm`=0 during RINGING → DISARMED, `led`=0 next cycle.
- `arm`=1 while `number` is held at 070000 → no ring. `number` changes to 070001 → no ring.
- `rst_n`=0 for one cycle mid-ring → all outputs at reset values; no ring until the next transition into `alarm_time`.
